uart_mem_dump: RTL and testbench

Memory readback transmitter for the UART programming path. The programmer receives words over `rx` and writes instruction or data memory; this block does the reverse. On a start pulse it reads a block of 32-bit words from either memory through a synchronous read port and streams them out on a UART TX line (8N1, LSB byte first), followed by an 8-bit checksum. It sits beside the programmer at the CPU top and shares its 15-bit address map, where bit 14 = 1 selects data memory and bit 14 = 0 selects instruction memory.

---
 rtl/uart_mem_dump.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_mem_dump.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_dump.sv
// uart_mem_dump: reads a block of 32-bit words from instruction or data
// memory through a 1-cycle synchronous read port and streams them out as
// 8N1 UART frames (LSB byte first), followed by an 8-bit additive checksum.
// Every output is registered, so it trails the state register by one cycle.
module uart_mem_dump #(
    parameter int BAUD_DIV = 868,
    parameter int ADDR_W   = 14
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start_i,
    input  logic              region_i,
    input  logic [ADDR_W-1:0] base_adr_i,
    input  logic [ADDR_W:0]   word_cnt_i,
    output logic              mem_re_o,
    output logic [ADDR_W:0]   mem_adr_o,
    input  logic [31:0]       mem_dat_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0]     BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]     BAUD_ONE  = BW'(1);
    localparam logic [ADDR_W-1:0] ADR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SEND  = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic              region_q, region_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [7:0]        csum_q, csum_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic              cap_q, cap_d;
    logic              re_q, re_d;
    logic [ADDR_W:0]   madr_q, madr_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        cur_byte_s;

    // Sum of the four bytes of a word, carries out of bit 7 dropped.
    function automatic logic [7:0] word_byte_sum(input logic [31:0] w);
        word_byte_sum = w[7:0] + w[15:8] + w[23:16] + w[31:24];
    endfunction

    // Line level for bit cell idx of an 8N1 frame: 0 start, 1..8 data, 9 stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic [7:0] sh;
        sh = 8'd0;
        if (idx == 4'd0) begin
            frame_bit = 1'b0;
        end else if (idx >= 4'd9) begin
            frame_bit = 1'b1;
        end else begin
            sh        = b >> (idx - 4'd1);
            frame_bit = sh[0];
        end
    endfunction

    // Select the byte of the captured word currently on the line.
    always_comb begin
        cur_byte_s = 8'd0;
        case (byte_q)
            2'd0:    cur_byte_s = shift_q[7:0];
            2'd1:    cur_byte_s = shift_q[15:8];
            2'd2:    cur_byte_s = shift_q[23:16];
            default: cur_byte_s = shift_q[31:24];
        endcase
    end

    // Next-state and next-output logic of the dump sequencer.
    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        adr_d    = adr_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        csum_d   = csum_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        cap_d    = 1'b0;
        re_d     = 1'b0;
        madr_d   = madr_q;
        tx_d     = 1'b1;
        done_d   = 1'b0;
        busy_d   = (state_q != S_IDLE) && (state_q != S_DONE);

        // The read strobe leaves the block one cycle after FETCH, so the word
        // arrives one edge after WAIT; it is taken in here, while the start bit
        // of its first byte (which needs no data) is already on the line.
        if (cap_q) begin
            shift_d = mem_dat_i;
            csum_d  = csum_q + word_byte_sum(mem_dat_i);
        end else begin
            shift_d = shift_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    region_d = region_i;
                    adr_d    = base_adr_i;
                    cnt_d    = word_cnt_i;
                    csum_d   = 8'd0;
                    baud_d   = {BW{1'b0}};
                    bit_d    = 4'd0;
                    byte_d   = 2'd0;
                    if (word_cnt_i != {(ADDR_W + 1){1'b0}}) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_CSUM;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                re_d    = 1'b1;
                madr_d  = {region_q, adr_q};
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cap_d   = 1'b1;
                baud_d  = {BW{1'b0}};
                bit_d   = 4'd0;
                byte_d  = 2'd0;
                state_d = S_SEND;
            end
            S_SEND: begin
                tx_d = frame_bit(cur_byte_s, bit_q);
                if (baud_q == BAUD_LAST) begin
                    baud_d = {BW{1'b0}};
                    if (bit_q == 4'd9) begin
                        bit_d = 4'd0;
                        if (byte_q == 2'd3) begin
                            byte_d = 2'd0;
                            cnt_d  = cnt_q - CNT_ONE;
                            adr_d  = adr_q + ADR_ONE;
                            if (cnt_q == CNT_ONE) begin
                                state_d = S_CSUM;
                            end else begin
                                state_d = S_FETCH;
                            end
                        end else begin
                            byte_d = byte_q + 2'd1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_CSUM: begin
                tx_d = frame_bit(csum_q, bit_q);
                if (baud_q == BAUD_LAST) begin
                    baud_d = {BW{1'b0}};
                    if (bit_q == 4'd9) begin
                        bit_d   = 4'd0;
                        state_d = S_DONE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset puts the line idle at once.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_IDLE;
            region_q <= 1'b0;
            adr_q    <= {ADDR_W{1'b0}};
            cnt_q    <= {(ADDR_W + 1){1'b0}};
            shift_q  <= 32'd0;
            csum_q   <= 8'd0;
            baud_q   <= {BW{1'b0}};
            bit_q    <= 4'd0;
            byte_q   <= 2'd0;
            cap_q    <= 1'b0;
            re_q     <= 1'b0;
            madr_q   <= {(ADDR_W + 1){1'b0}};
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            adr_q    <= adr_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            csum_q   <= csum_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            cap_q    <= cap_d;
            re_q     <= re_d;
            madr_q   <= madr_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign mem_re_o  = re_q;
    assign mem_adr_o = madr_q;
    assign tx_o      = tx_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_uart_mem_dump.sv
// Bench for uart_mem_dump: a fast instance (BAUD_DIV=4) for function and a
// slow one (BAUD_DIV=868) for bit timing. Line activity is logged per cycle
// and decoded afterwards against a word-list reference model.
module tb_uart_mem_dump;

    localparam int BF = 4;
    localparam int BS = 868;
    localparam int AW = 14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_f, start_s, region;
    logic [13:0] base;
    logic [14:0] cnt;
    logic        re_f, re_s, tx_f, tx_s, busy_f, busy_s, done_f, done_s;
    logic [14:0] adr_f, adr_s;
    logic [31:0] dat_f, dat_s;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] mem [0:32767];
    bit tx_hist_f [0:65535];
    bit tx_hist_s [0:65535];
    bit busy_hist [0:65535];
    int          re_edge[$];
    logic [14:0] re_adr[$];
    int          done_edge[$];

    always #5 clk = ~clk;

    uart_mem_dump #(.BAUD_DIV(BF), .ADDR_W(AW)) dut_f (
        .sys_clk(clk), .sys_rst_n(rst_n), .start_i(start_f), .region_i(region),
        .base_adr_i(base), .word_cnt_i(cnt), .mem_re_o(re_f), .mem_adr_o(adr_f),
        .mem_dat_i(dat_f), .tx_o(tx_f), .busy_o(busy_f), .done_o(done_f));

    uart_mem_dump #(.BAUD_DIV(BS), .ADDR_W(AW)) dut_s (
        .sys_clk(clk), .sys_rst_n(rst_n), .start_i(start_s), .region_i(region),
        .base_adr_i(base), .word_cnt_i(cnt), .mem_re_o(re_s), .mem_adr_o(adr_s),
        .mem_dat_i(dat_s), .tx_o(tx_s), .busy_o(busy_s), .done_o(done_s));

    // Synchronous-read memory shared by both instances.
    always @(posedge clk) begin
        if (re_f) dat_f <= mem[adr_f];
        if (re_s) dat_s <= mem[adr_s];
    end

    // Edge counter: value k after the k-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle log of what follows edge cyc.
    always @(negedge clk) begin
        if (cyc < 65536) begin
            tx_hist_f[cyc] <= tx_f;
            tx_hist_s[cyc] <= tx_s;
            busy_hist[cyc] <= busy_f | busy_s;
        end
        if (re_f) begin re_edge.push_back(cyc); re_adr.push_back(adr_f); end
        if (re_s) begin re_edge.push_back(cyc); re_adr.push_back(adr_s); end
        if (done_f || done_s) done_edge.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit get_tx(input bit sel, input int k);
        if (k < 0 || k > 65535) return 1'b1;
        return sel ? tx_hist_s[k] : tx_hist_f[k];
    endfunction

    // One complete dump, checked against the reference word list.
    task automatic run_dump(input bit sel, input bit rg, input logic [13:0] bs,
                            input logic [14:0] wc, input bit disturb);
        int bd, n, t, s, e, re0, dn0, lim, got;
        int exp_start[$];
        logic [7:0] exp_byte[$];
        int exp_re[$];
        logic [14:0] exp_adr[$];
        int exp_done;
        logic [7:0] sum, rx;
        logic [31:0] w;
        logic [13:0] a;
        bit bad, first;

        bd  = sel ? BS : BF;
        re0 = re_edge.size();
        dn0 = done_edge.size();
        @(negedge clk);
        region = rg; base = bs; cnt = wc;
        if (sel) start_s = 1'b1; else start_f = 1'b1;
        @(negedge clk);
        n = cyc;
        start_f = 1'b0; start_s = 1'b0;

        // Reference: 2 idle cycles before each word, back-to-back frames.
        t = n + 1; sum = 8'd0; a = bs;
        for (int i = 0; i < int'(wc); i++) begin
            exp_re.push_back(t);
            exp_adr.push_back({rg, a});
            w = mem[{rg, a}];
            t += 2;
            for (int b = 0; b < 4; b++) begin
                exp_byte.push_back(w[8*b +: 8]);
                exp_start.push_back(t);
                sum += w[8*b +: 8];
                t += 10 * bd;
            end
            a = a + 14'd1;
        end
        exp_byte.push_back(sum);
        exp_start.push_back(t);
        exp_done = t + 10 * bd;

        lim = exp_done + 20;
        while (done_edge.size() == dn0 && cyc < lim) begin
            if (disturb && cyc == n + 3 + 10 * bd + 2) begin
                start_f = 1'b1; base = ~bs; region = ~rg;
            end else begin
                start_f = 1'b0;
            end
            @(negedge clk);
        end
        start_f = 1'b0; base = bs; region = rg;
        repeat (3) @(negedge clk);

        check("done_count", done_edge.size() - dn0, 1);
        got = (done_edge.size() > dn0) ? done_edge[dn0] : -1;
        check("done_edge", got - n, exp_done - n);
        check("busy_start", busy_hist[n + 1], 1'b1);
        check("busy_last", busy_hist[exp_done - 1], 1'b1);
        check("busy_end", busy_hist[exp_done], 1'b0);

        check("re_count", re_edge.size() - re0, exp_re.size());
        for (int i = 0; i < exp_re.size(); i++) begin
            got = (re0 + i < re_edge.size()) ? re_edge[re0 + i] : -1;
            check("re_edge", got - n, exp_re[i] - n);
            check("re_adr", (re0 + i < re_adr.size()) ? re_adr[re0 + i] : 15'h0, exp_adr[i]);
        end

        e = n;
        for (int f = 0; f < exp_byte.size(); f++) begin
            s = -1;
            for (int k = e; k < e + 20 * bd + 10 && k < cyc; k++) begin
                if (get_tx(sel, k) == 1'b0) begin s = k; break; end
            end
            check("frame_start", s - n, exp_start[f] - n);
            if (s < 0) s = exp_start[f];
            bad = 1'b0; rx = 8'd0;
            for (int c = 0; c < 10; c++) begin
                first = get_tx(sel, s + c * bd);
                for (int j = 1; j < bd; j++)
                    if (get_tx(sel, s + c * bd + j) != first) bad = 1'b1;
                if (c == 0 && first != 1'b0) bad = 1'b1;
                if (c == 9 && first != 1'b1) bad = 1'b1;
                if (c >= 1 && c <= 8) rx[c - 1] = first;
            end
            check("frame_byte", rx, exp_byte[f]);
            check("frame_cells", bad, 1'b0);
            e = s + 10 * bd;
        end
    endtask

    initial begin
        int k, dn0, r;
        logic [13:0] bs, a;
        logic [14:0] wc;
        bit rg;

        for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
        rst_n = 1'b0; start_f = 1'b0; start_s = 1'b0;
        region = 1'b0; base = 14'h0; cnt = 15'h0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_f, 1'b1);
        check("rst_busy", busy_f, 1'b0);
        check("rst_done", done_f, 1'b0);
        check("rst_re", re_f, 1'b0);
        check("rst_adr", adr_f, 15'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single word, known checksum 0x14.
        mem[15'h0000] = 32'h12345678;
        run_dump(1'b0, 1'b0, 14'h0000, 15'd1, 1'b0);

        // Zero words: checksum frame 0x00 only.
        run_dump(1'b0, 1'b1, 14'h0123, 15'd0, 1'b0);

        // Address wrap within data memory, checksum 0xFD.
        mem[15'h7FFF] = 32'hFFFFFFFF;
        mem[15'h4000] = 32'h00000001;
        run_dump(1'b0, 1'b1, 14'h3FFF, 15'd2, 1'b0);

        // Start pulse with another base during the second byte is ignored.
        mem[15'h0100] = $urandom;
        mem[15'h0101] = $urandom;
        run_dump(1'b0, 1'b0, 14'h0100, 15'd2, 1'b1);

        // Reset in the middle of the first start bit.
        @(negedge clk);
        region = 1'b0; base = 14'h0200; cnt = 15'd1; start_f = 1'b1;
        @(negedge clk);
        start_f = 1'b0;
        k = 0;
        while (tx_f !== 1'b0 && k < 10) begin @(negedge clk); k++; end
        check("rst_mid_txlow", tx_f, 1'b0);
        dn0 = done_edge.size();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx", tx_f, 1'b1);
        check("rst_mid_busy", busy_f, 1'b0);
        check("rst_mid_done", done_f, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("rst_mid_nodone", done_edge.size() - dn0, 0);
        check("rst_mid_idle", tx_f, 1'b1);
        mem[15'h0200] = $urandom;
        run_dump(1'b0, 1'b0, 14'h0200, 15'd1, 1'b0);

        // Randomised dumps, one forced next to the address wrap.
        for (r = 0; r < 4; r++) begin
            rg = 1'($urandom_range(0, 1));
            bs = (r == 0) ? 14'h3FFE : 14'($urandom);
            wc = 15'($urandom_range(1, 3));
            a  = bs;
            for (int i = 0; i < int'(wc); i++) begin
                mem[{rg, a}] = $urandom;
                a = a + 14'd1;
            end
            run_dump(1'b0, rg, bs, wc, 1'b0);
        end

        // Bit timing at the real baud divisor.
        mem[15'h0020] = $urandom;
        run_dump(1'b1, 1'b0, 14'h0020, 15'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
